// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and small helpers for the common-data-bus arbiter.
// Defaults for result/label width and the null label used on idle cycles.
package cdb_arbiter_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_LABEL_W = 4;
    localparam int unsigned NULL_LABEL  = 0;

    // Saturating 16-bit increment used by the optional performance counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin pick: first set bit of req at or after ptr, searching upward modulo N.
// Output is one-hot, or zero when nothing is requesting.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Rotating priority search starting at ptr.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant of one FU result per cycle onto a registered broadcast.
// Optional performance counters (bcastCount, conflictCount) when CDB_PERF_CNT_EN is defined.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU  = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LABEL_W = DEF_LABEL_W
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic [NUM_FU-1:0]         require,
    input  logic [NUM_FU*DATA_W-1:0]  reqData,
    input  logic [NUM_FU*LABEL_W-1:0] reqLabel,
    input  logic                      cdbStall,
    output logic [NUM_FU-1:0]         requireAC,
    output logic                      cdbValid,
    output logic [LABEL_W-1:0]        cdbLabel,
`ifdef CDB_PERF_CNT_EN
    output logic [15:0]               bcastCount,
    output logic [15:0]               conflictCount,
`endif
    output logic [DATA_W-1:0]         cdbData
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_valid;
    logic [LABEL_W-1:0] r_label;
    logic [DATA_W-1:0]  r_data;

    logic [NUM_FU-1:0]  w_pick;
    logic               w_granted;
    logic [PTR_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic [LABEL_W-1:0] w_sel_label;

    rr_picker #(
        .N  (NUM_FU),
        .PW (PTR_W)
    ) u_picker (
        .req   (require),
        .ptr   (r_rr_ptr),
        .grant (w_pick)
    );

    // Grant is suppressed during reset and stall; it never looks at data or labels.
    always_comb begin
        if (!nRST || cdbStall) begin
            requireAC = '0;
        end else begin
            requireAC = w_pick;
        end
    end

    assign w_granted = |requireAC;

    // Decode the granted FU into an index and select its result and label.
    always_comb begin
        w_idx       = '0;
        w_sel_data  = '0;
        w_sel_label = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (requireAC[i]) begin
                w_idx       = PTR_W'(i);
                w_sel_data  = reqData[i*DATA_W +: DATA_W];
                w_sel_label = reqLabel[i*LABEL_W +: LABEL_W];
            end else begin
                w_idx = w_idx;
            end
        end
    end

    // Broadcast register and round-robin pointer; idle cycles null the label but keep the data.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_valid  <= 1'b0;
            r_label  <= LABEL_W'(NULL_LABEL);
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else if (w_granted) begin
            r_valid  <= 1'b1;
            r_label  <= w_sel_label;
            r_data   <= w_sel_data;
            r_rr_ptr <= (w_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_idx + 1'b1;
        end else begin
            r_valid  <= 1'b0;
            r_label  <= LABEL_W'(NULL_LABEL);
            r_data   <= r_data;
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign cdbValid = r_valid;
    assign cdbLabel = r_label;
    assign cdbData  = r_data;

`ifdef CDB_PERF_CNT_EN
    logic [15:0] r_bcast_cnt;
    logic [15:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = ($countones(require) >= 2) && !cdbStall;

    // Saturating counters of broadcasts and of cycles with competing requesters.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_bcast_cnt    <= 16'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            r_bcast_cnt    <= w_granted  ? sat_inc16(r_bcast_cnt)    : r_bcast_cnt;
            r_conflict_cnt <= w_conflict ? sat_inc16(r_conflict_cnt) : r_conflict_cnt;
        end
    end

    assign bcastCount    = r_bcast_cnt;
    assign conflictCount = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with NUM_FU=4, DATA_W=32, LABEL_W=4.
// Per-FU labels are fixed (FU0=1, FU1=3, FU2=5, FU3=7) so each broadcast identifies its source.
module tb_cdb_arbiter;

    logic         clk;
    logic         nRST;
    logic [3:0]   require;
    logic [127:0] reqData;
    logic [15:0]  reqLabel;
    logic         cdbStall;
    logic [3:0]   requireAC;
    logic         cdbValid;
    logic [3:0]   cdbLabel;
    logic [31:0]  cdbData;
`ifdef CDB_PERF_CNT_EN
    logic [15:0]  bcastCount;
    logic [15:0]  conflictCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(
        .NUM_FU  (4),
        .DATA_W  (32),
        .LABEL_W (4)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .reqData   (reqData),
        .reqLabel  (reqLabel),
        .cdbStall  (cdbStall),
        .requireAC (requireAC),
        .cdbValid  (cdbValid),
        .cdbLabel  (cdbLabel),
`ifdef CDB_PERF_CNT_EN
        .bcastCount    (bcastCount),
        .conflictCount (conflictCount),
`endif
        .cdbData   (cdbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, check the combinational grant mid-cycle, then the registered beat after the edge.
    task automatic step(input string tag, input logic [3:0] req, input logic stall,
                        input logic [3:0] exp_gnt, input logic exp_v, input logic [3:0] exp_lbl);
        require  = req;
        cdbStall = stall;
        #4;
        check_val({tag, " grant"}, 32'(requireAC), 32'(exp_gnt));
        @(posedge clk);
        #1;
        check_val({tag, " valid"}, 32'(cdbValid), 32'(exp_v));
        check_val({tag, " label"}, 32'(cdbLabel), 32'(exp_lbl));
    endtask

    initial begin
        nRST     = 1'b0;
        require  = 4'b1111;
        cdbStall = 1'b0;
        reqData  = {32'h0000_0033, 32'h0000_0022, 32'h0000_00AA, 32'h0000_0011};
        reqLabel = {4'h7, 4'h5, 4'h3, 4'h1};
        #2;
        check_val("rst grant", 32'(requireAC), 32'h0);
        check_val("rst valid", 32'(cdbValid), 32'h0);
        check_val("rst label", 32'(cdbLabel), 32'h0);
        check_val("rst data", cdbData, 32'h0);
        check_val("rst ptr", 32'(dut.r_rr_ptr), 32'h0);
        require = 4'b0000;
        @(posedge clk);
        #1;
        nRST = 1'b1;

        // Single FU1 request, then an idle cycle that nulls the label but keeps data
        step("fu1", 4'b0010, 1'b0, 4'b0010, 1'b1, 4'h3);
        check_val("fu1 data", cdbData, 32'h0000_00AA);
        check_val("fu1 ptr", 32'(dut.r_rr_ptr), 32'h2);
        step("idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0);
        check_val("idle data", cdbData, 32'h0000_00AA);
        check_val("idle ptr", 32'(dut.r_rr_ptr), 32'h2);

        // Move ptr to 3, then 1001 wraps FU3 -> FU0
        step("fu2", 4'b0100, 1'b0, 4'b0100, 1'b1, 4'h5);
        check_val("fu2 ptr", 32'(dut.r_rr_ptr), 32'h3);
        step("wrap3", 4'b1001, 1'b0, 4'b1000, 1'b1, 4'h7);
        check_val("wrap3 ptr", 32'(dut.r_rr_ptr), 32'h0);
        step("wrap0", 4'b1001, 1'b0, 4'b0001, 1'b1, 4'h1);
        check_val("wrap0 ptr", 32'(dut.r_rr_ptr), 32'h1);

        // Three stalled cycles, then FU2 granted right after release
        step("stall1", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'h0);
        step("stall2", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'h0);
        step("stall3", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'h0);
        check_val("stall ptr", 32'(dut.r_rr_ptr), 32'h1);
        step("unstall", 4'b0100, 1'b0, 4'b0100, 1'b1, 4'h5);
        check_val("unstall data", cdbData, 32'h0000_0022);
        step("stall mid", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'h0);

        // Sole requester gets back-to-back grants
        step("b2b a", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("b2b b", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1);
        check_val("b2b ptr", 32'(dut.r_rr_ptr), 32'h1);

        // Grant independent of data; new data captured on grant
        reqData[63:32] = 32'hDEAD_BEEF;
        step("newdata", 4'b0110, 1'b0, 4'b0010, 1'b1, 4'h3);
        check_val("newdata data", cdbData, 32'hDEAD_BEEF);
        reqData[63:32] = 32'h0000_00AA;

        // Mid-stream reset with cdbValid high
        step("pre rst", 4'b1111, 1'b0, 4'b0100, 1'b1, 4'h5);
        nRST = 1'b0;
        #1;
        check_val("mid rst valid", 32'(cdbValid), 32'h0);
        check_val("mid rst label", 32'(cdbLabel), 32'h0);
        check_val("mid rst data", cdbData, 32'h0);
        check_val("mid rst grant", 32'(requireAC), 32'h0);
        check_val("mid rst ptr", 32'(dut.r_rr_ptr), 32'h0);
        #1;
        nRST = 1'b1;

        // All four request continuously: 0,1,2,3,0
        step("all g0", 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("all g1", 4'b1111, 1'b0, 4'b0010, 1'b1, 4'h3);
        step("all g2", 4'b1111, 1'b0, 4'b0100, 1'b1, 4'h5);
        step("all g3", 4'b1111, 1'b0, 4'b1000, 1'b1, 4'h7);
        check_val("all g3 data", cdbData, 32'h0000_0033);
        step("all g0b", 4'b1111, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("all off", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0);

`ifdef CDB_PERF_CNT_EN
        nRST = 1'b0;
        #1;
        check_val("perf rst bcast", 32'(bcastCount), 32'h0);
        check_val("perf rst conflict", 32'(conflictCount), 32'h0);
        nRST = 1'b1;
        step("perf a", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("perf b", 4'b0011, 1'b0, 4'b0010, 1'b1, 4'h3);
        step("perf c", 4'b0011, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("perf d", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("perf e", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1);
        step("perf stall", 4'b0011, 1'b1, 4'b0000, 1'b0, 4'h0);
        check_val("perf bcast", 32'(bcastCount), 32'd5);
        check_val("perf conflict", 32'(conflictCount), 32'd2);
        force dut.r_bcast_cnt = 16'hFFFF;
        #1;
        release dut.r_bcast_cnt;
        step("perf sat", 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h1);
        check_val("perf sat bcast", 32'(bcastCount), 32'h0000_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32: result width.
REQ-003 SHALL have parameter LABEL_W, default 4: reservation-station label width.
REQ-004 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have nRST  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have require  input  NUM_FU  per-FU broadcast request; bit i from FU i.
REQ-007 SHALL have reqData  input  NUM_FU*DATA_W  packed FU results; slice i belongs to FU i.
REQ-008 SHALL have reqLabel  input  NUM_FU*LABEL_W  packed FU labels; slice i belongs to FU i.
REQ-009 SHALL have cdbStall  input  1  blocks all grants while high.
REQ-010 SHALL have requireAC  output  NUM_FU  one-hot grant, combinational.
REQ-011 SHALL have cdbValid  output  1  registered; broadcast valid.
REQ-012 SHALL have cdbLabel  output  LABEL_W  registered; broadcast label.
REQ-013 SHALL have cdbData  output  DATA_W  registered; broadcast result.

Function
REQ-014 SHALL drive requireAC with at most one bit set in any cycle.
REQ-015 SHALL drive requireAC to zero when cdbStall=1 or require=0.
REQ-016 SHALL otherwise grant the first requesting FU at or after rrPtr, searching upward modulo NUM_FU.
REQ-017 SHALL make requireAC depend only on require, cdbStall and rrPtr, never on reqData or reqLabel.
REQ-018 SHALL hand off on a granted edge: FU sees requireAC=1 at the edge; arbiter captures that FU's reqData/reqLabel at the same edge.
REQ-019 SHALL present the captured beat the next cycle with cdbValid=1: one cycle request-to-broadcast latency.
REQ-020 SHALL update rrPtr to (granted index + 1) mod NUM_FU on a granted edge; wrap from NUM_FU-1 to 0.
REQ-021 SHALL hold rrPtr on edges with no grant.
REQ-022 SHALL on edges with no grant: cdbValid<=0, cdbLabel<=0 (null label), cdbData holds its last value.
REQ-023 SHALL keep a requester with require=1 and no grant in arbitration on following cycles; nothing is dropped.
REQ-024 SHALL grant any continuously requesting FU within NUM_FU cycles while cdbStall=0.
REQ-025 SHALL allow back-to-back grants to the same FU when it is the only requester.
REQ-026 SHALL ignore a request in the cycle it is deasserted; no grant is recorded.
REQ-027 SHALL let a stall rising mid-stream finish the beat already captured; no new beat is captured until cdbStall falls.

Reset
REQ-028 SHALL on nRST low, asynchronously: cdbValid=0, cdbLabel=0, cdbData=0, rrPtr=0.
REQ-029 SHALL hold requireAC at zero while nRST is low.
REQ-030 SHALL discard a beat captured in the same cycle reset asserts.

Configuration
REQ-031 SHALL with macro CDB_PERF_CNT_EN defined add outputs bcastCount[15:0] and conflictCount[15:0].
REQ-032 SHALL with CDB_PERF_CNT_EN: bcastCount +1 per granted edge; conflictCount +1 per edge with two or more require bits set and cdbStall=0; both saturate at 16'hFFFF and reset to 0.
REQ-033 SHALL without CDB_PERF_CNT_EN omit both ports and counters; all other behaviour identical.

Structure
REQ-034 SHALL keep NULL_LABEL (0), default DATA_W and default LABEL_W in the shared head.v constants package.
REQ-035 SHALL place the rotate-and-pick logic in sub-module rr_picker (inputs req, ptr; output one-hot grant).

Verification
REQ-036 SHALL check: single FU1 requests, data 32'h0000_00AA, label 4'h3 -> requireAC=4'b0010; next cycle cdbValid=1, cdbLabel=3, cdbData=AA; rrPtr=2.
REQ-037 SHALL check: all four FUs request continuously from reset -> grants 0,1,2,3,0 on consecutive cycles; each label appears once per 4 cycles.
REQ-038 SHALL check: rrPtr=3, requests 4'b1001 -> grant FU3, then FU0 (wrap-around).
REQ-039 SHALL check: cdbStall=1 for 3 cycles with require=4'b0100 -> requireAC=0 and cdbValid=0 throughout; FU2 granted on the first cycle after stall falls.
REQ-040 SHALL check: nRST pulsed low mid-stream with cdbValid=1 -> outputs 0 immediately; first grant after release goes to lowest requesting index.
REQ-041 SHALL check, with CDB_PERF_CNT_EN defined: 5 grants with 2 conflict cycles -> bcastCount=5, conflictCount=2; a counter preloaded to FFFF stays FFFF.
